// File: rtl/flatten_pkg.sv
// Shared definitions for the flatten path: element width, frame depth and
// the streamer state encoding (also used by the collecting buffer).
package flatten_pkg;

    localparam int DATA_W     = 22;
    localparam int FLAT_DEPTH = 225;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } flatten_state_e;

endpackage

// File: rtl/flatten_streamer.sv
// Captures a parallel frame on start and streams it one element per
// valid/ready handshake, then pulses done for one cycle.
//
// state     | meaning
// ST_IDLE   | waiting for i_start; snapshot holds last frame
// ST_STREAM | presenting snapshot[index], advancing on i_ready
// ST_DONE   | one-cycle o_done pulse, then back to idle
module flatten_streamer #(
    parameter int DATA_W = flatten_pkg::DATA_W,
    parameter int DEPTH  = flatten_pkg::FLAT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic signed [DATA_W-1:0] i_flattened_data [0:DEPTH-1],
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_last,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    flatten_pkg::flatten_state_e state, state_nxt;
    logic [IDX_W-1:0]            index;
    logic signed [DATA_W-1:0]    snapshot [0:DEPTH-1];
    logic                        at_last;

    assign at_last = (index == LAST_IDX);

    always_comb begin
        state_nxt = state;
        case (state)
            flatten_pkg::ST_IDLE:   if (i_start) state_nxt = flatten_pkg::ST_STREAM;
            flatten_pkg::ST_STREAM: if (i_ready && at_last) state_nxt = flatten_pkg::ST_DONE;
            flatten_pkg::ST_DONE:   state_nxt = flatten_pkg::ST_IDLE;
            default:                state_nxt = flatten_pkg::ST_IDLE;
        endcase
    end

    // Snapshot only loads on an accepted start; index saturates at the last element.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= flatten_pkg::ST_IDLE;
            index    <= '0;
            snapshot <= '{default: '0};
        end else begin
            state <= state_nxt;
            if (state == flatten_pkg::ST_IDLE && i_start) begin
                snapshot <= i_flattened_data;
                index    <= '0;
            end else if (state == flatten_pkg::ST_STREAM && i_ready && !at_last) begin
                index <= index + 1'b1;
            end
        end
    end

    assign o_valid = (state == flatten_pkg::ST_STREAM);
    assign o_busy  = (state == flatten_pkg::ST_STREAM);
    assign o_done  = (state == flatten_pkg::ST_DONE);
    assign o_last  = o_valid && at_last;
    assign o_data  = snapshot[index];

endmodule

// File: tb/tb_flatten_streamer.sv
// Scoreboard bench for flatten_streamer: stimulus pushes expected elements,
// a negedge monitor pops and compares on every handshake.
module tb_flatten_streamer;

    localparam int DW = 22;
    localparam int DP = 225;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_start = 1'b0;
    logic                 i_ready = 1'b0;
    logic signed [DW-1:0] frame [0:DP-1];
    logic                 o_valid, o_last, o_busy, o_done;
    logic signed [DW-1:0] o_data;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    flatten_streamer #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_flattened_data (frame),
        .i_ready          (i_ready),
        .o_valid          (o_valid),
        .o_data           (o_data),
        .o_last           (o_last),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every handshake must match the head of the expected queue,
    // and a stalled element must not change on the following cycle.
    logic                 stall_prev = 1'b0;
    logic signed [DW-1:0] stall_data = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && o_valid)
                    check("stall_hold", 32'($signed(o_data)), 32'($signed(stall_data)));
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", 32'(o_valid), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("data", 32'($signed(o_data)), 32'($signed(e.data)));
                        check("last", 32'(o_last), 32'(e.last));
                    end
                end
                stall_prev = o_valid && !i_ready;
                stall_data = o_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_frame();
        exp_t e;
        for (int k = 0; k < DP; k++) begin
            e.data = frame[k];
            e.last = (k == DP - 1);
            exp_q.push_back(e);
        end
    endtask

    // ready_mode 0: always ready; 1: pattern 1,0,0. restart_at: cycle of a
    // spurious second start (-1 none). corrupt: overwrite frame after capture.
    task automatic run_frame(input int ready_mode, input int restart_at, input bit corrupt,
                             output int done_at, output int done_cnt);
        int cyc;
        done_at  = -1;
        done_cnt = 0;
        i_start  = 1'b1;
        i_ready  = (ready_mode == 0);
        push_frame();
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 0;
        while (cyc < 3000 && !(done_at >= 0 && cyc > done_at + 3)) begin
            i_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            i_start = (cyc == restart_at);
            if (corrupt && cyc == 0)
                for (int k = 0; k < DP; k++) frame[k] = -22'sd1;
            if (cyc == 0) check("first_valid", 32'(o_valid), 32'(1));
            @(negedge clk);
            if (o_done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_start = 1'b0;
        if (done_at < 0) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic set_ramp();
        for (int k = 0; k < DP; k++) frame[k] = 22'(k - 112);
    endtask

    initial begin
        int done_at, done_cnt, saw_done;
        set_ramp();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'(0));
        check("rst_last",  32'(o_last),  32'(0));
        check("rst_busy",  32'(o_busy),  32'(0));
        check("rst_done",  32'(o_done),  32'(0));
        check("rst_data",  32'($signed(o_data)), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Continuous ready: done in cycle after edge N+225.
        run_frame(0, -1, 1'b0, done_at, done_cnt);
        check("ramp_done_at",  32'(done_at),  32'(225));
        check("ramp_done_cnt", 32'(done_cnt), 32'(1));
        check("ramp_busy_after", 32'(o_busy), 32'(0));
        check("ramp_q_empty", 32'(exp_q.size()), 32'(0));

        // Ready 1,0,0: transfers on cycles 0,3,...,672 -> done at 673.
        run_frame(1, -1, 1'b0, done_at, done_cnt);
        check("stall_done_at",  32'(done_at),  32'(673));
        check("stall_done_cnt", 32'(done_cnt), 32'(1));
        check("stall_q_empty", 32'(exp_q.size()), 32'(0));

        // Input frame overwritten after capture.
        run_frame(0, -1, 1'b1, done_at, done_cnt);
        check("snap_done_at", 32'(done_at), 32'(225));
        check("snap_q_empty", 32'(exp_q.size()), 32'(0));

        // Second start at index 50 is ignored.
        set_ramp();
        run_frame(0, 50, 1'b0, done_at, done_cnt);
        check("restart_done_at",  32'(done_at),  32'(225));
        check("restart_done_cnt", 32'(done_cnt), 32'(1));
        check("restart_q_empty", 32'(exp_q.size()), 32'(0));

        // Reset at index 100 with a simultaneous transfer.
        i_start = 1'b1;
        i_ready = 1'b1;
        push_frame();
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_q_left", 32'(exp_q.size()), 32'(DP - 100));
        exp_q.delete();
        check("rst_mid_valid", 32'(o_valid), 32'(0));
        check("rst_mid_busy",  32'(o_busy),  32'(0));
        saw_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_done) saw_done++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_done", 32'(saw_done), 32'(0));
        for (int k = 0; k < DP; k++) frame[k] = 22'sh1FFFFF;
        run_frame(0, -1, 1'b0, done_at, done_cnt);
        check("post_rst_done_at", 32'(done_at), 32'(225));
        check("post_rst_q_empty", 32'(exp_q.size()), 32'(0));

        // Alternating extremes, with stalls.
        for (int k = 0; k < DP; k++) frame[k] = (k % 2 == 0) ? 22'sh1FFFFF : 22'sh200000;
        run_frame(1, -1, 1'b0, done_at, done_cnt);
        check("ext_done_at", 32'(done_at), 32'(673));
        check("ext_q_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flatten_streamer.md
FLATTEN_STREAMER -- requirements
Module: flatten_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 22, meaning signed element width.
REQ-002 SHALL have parameter DEPTH, default 225, meaning number of elements per frame.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port i_start  input  1  one-cycle request to capture and stream a frame.
REQ-006 SHALL have port i_flattened_data  input  DATA_W signed x [0:DEPTH-1]  parallel frame, sampled only on an accepted start.
REQ-007 SHALL have port i_ready  input  1  downstream accepts the current element.
REQ-008 SHALL have port o_valid  output  1  o_data holds a valid element.
REQ-009 SHALL have port o_data  output  DATA_W signed  current element.
REQ-010 SHALL have port o_last  output  1  current element is index DEPTH-1.
REQ-011 SHALL have port o_busy  output  1  frame captured, streaming not finished.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse after the last transfer.

Function
REQ-013 SHALL implement the states IDLE, STREAM and DONE.
REQ-014 In IDLE, i_start=1 SHALL copy all DEPTH elements into an internal snapshot, clear the read index to 0, and enter STREAM on the same edge.
REQ-015 i_start SHALL be ignored in STREAM and DONE; the snapshot SHALL NOT change outside an accepted start.
REQ-016 o_valid SHALL be 1 exactly while in STREAM; the first element SHALL be valid on the cycle after the start is accepted (latency 1).
REQ-017 o_data SHALL equal snapshot[index] and SHALL remain stable while o_valid=1 and i_ready=0.
REQ-018 A transfer SHALL occur on an edge where o_valid=1 and i_ready=1.
REQ-019 On a transfer with index<DEPTH-1, index SHALL increment by 1.
REQ-020 On a transfer with index==DEPTH-1, the state SHALL go to DONE and index SHALL hold.
REQ-021 o_last SHALL be 1 only while o_valid=1 and index==DEPTH-1.
REQ-022 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-023 o_busy SHALL be 1 in STREAM and 0 in IDLE and DONE.
REQ-024 With i_ready held at 1 and start accepted at edge N, transfers SHALL occur on edges N+1..N+DEPTH and o_done SHALL be high in the cycle after edge N+DEPTH.
REQ-025 i_ready SHALL have no effect outside STREAM; i_ready low indefinitely SHALL stall without loss or duplication.
REQ-026 The index SHALL be ceil(log2(DEPTH)) bits (8 for 225) and SHALL never exceed DEPTH-1; there is no wrap-around.
REQ-027 o_data SHALL be driven from registered state only; there is no combinational path from i_ready or i_start to o_data or o_valid.

Reset
REQ-028 On rst=1 at an edge: state=IDLE, index=0 and snapshot all zero.
REQ-029 On rst=1 at an edge: o_valid=0, o_last=0, o_busy=0, o_done=0 and o_data=0.
REQ-030 rst SHALL take priority over i_start and over any transfer in the same cycle.
REQ-031 rst mid-frame SHALL abort with no o_done pulse; a new start after reset SHALL stream from index 0.

Structure
REQ-032 DATA_W=22, FLAT_DEPTH=225 and the state enum typedef SHALL live in the shared package flatten_pkg, shared with the collecting buffer.
REQ-033 No sub-module is required; the snapshot, index counter and FSM SHALL be in one always_ff, with the output mux as continuous assignment.

Verification
REQ-034 Frame element[k]=k-112, i_ready=1, start pulse: o_data sequence -112..112 over 225 consecutive cycles; o_last on the 225th only; o_done one cycle later; o_busy low afterwards.
REQ-035 Same frame, i_ready toggling 1,0,0 repeating: exactly 225 transfers in order; o_data stable during each stall; no duplicate or skipped element.
REQ-036 i_flattened_data changed to all -1 one cycle after start: streamed values still k-112.
REQ-037 Second i_start pulsed at stream index 50: ignored; total 225 transfers, single o_done.
REQ-038 rst asserted at index 100 with a simultaneous transfer: next cycle o_valid=0, o_busy=0, no o_done; a new start with element[k]=0x1FFFFF streams 225 values starting at index 0.
REQ-039 Extremes: elements alternating 22'sh1FFFFF / 22'sh200000: output bit-exact, sign preserved.
